// File: rtl/sram_sp_clr.sv
// Single-port byte-maskable SRAM that self-initialises to CLR_VALUE after reset
// and on request, refusing accesses while the clear sweep runs.
module sram_sp_clr #(
  parameter int             W         = 32,
  parameter int             DEPTH     = 256,
  parameter logic [W-1:0]   CLR_VALUE = '0,
  localparam int            AW        = $clog2(DEPTH),
  localparam int            NB        = W / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [NB-1:0] wmask,
  input  logic [W-1:0]  wdata,
  input  logic          clr_req,
  output logic          ready,
  output logic          busy,
  output logic [W-1:0]  rdata,
  output logic          rvalid
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    rdata_q;
  logic            rvalid_q;
  logic [W-1:0]    mem [DEPTH];

  logic            we;
  logic [NB-1:0]   be;
  logic [AW-1:0]   waddr;
  logic [W-1:0]    wdat;
  logic            rd_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    be      = '0;
    waddr   = addr;
    wdat    = wdata;
    rd_en   = 1'b0;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        be    = '1;
        waddr = cnt_q;
        wdat  = CLR_VALUE;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (req) begin
          if (wen) begin
            we = 1'b1;
            be = wmask;
          end else begin
            rd_en = 1'b1;
          end
        end
        // A same-edge access still completes; the sweep's first write lands next edge.
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= mem[addr];
    end
  end

  // Array has no reset; writes are suppressed while rst is held so a reset aborts cleanly.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  assign ready  = (state_q == RUN);
  assign busy   = !ready;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: doc/sram_sp_clr.md
SRAM_SP_CLR -- requirements
Module: sram_sp_clr

Interface
REQ-001 Parameter W, default 32: data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 256: word count; SHALL be a power of two, minimum 2; AW = log2(DEPTH).
REQ-003 Parameter CLR_VALUE, default 0 (W bits): value written to every word by a clear sweep.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset; asynchronous assert, active-high.
REQ-006 req  in  1  access request; sampled only when ready=1.
REQ-007 wen  in  1  1 = write access, 0 = read access.
REQ-008 addr  in  AW  word address.
REQ-009 wmask  in  W/8  active-high byte enables for writes; ignored on reads.
REQ-010 wdata  in  W  write data.
REQ-011 clr_req  in  1  request a full-array clear sweep; sampled only when ready=1.
REQ-012 ready  out  1  1 = accepting req and clr_req this cycle.
REQ-013 busy  out  1  1 = clear sweep in progress; always equals !ready.
REQ-014 rdata  out  W  read data.
REQ-015 rvalid  out  1  1-cycle pulse marking new rdata.

Function
REQ-016 The FSM SHALL have two states, CLEAR and RUN; the reset state SHALL be CLEAR with the sweep counter at 0.
REQ-017 In CLEAR, each clk edge SHALL write CLR_VALUE to word[counter] and increment the counter; the edge that writes word DEPTH-1 SHALL move the FSM to RUN with the counter wrapping to 0.
REQ-018 The first clear write SHALL occur on the first rising edge after rst deasserts; ready SHALL become 1 exactly DEPTH edges after rst deasserts.
REQ-019 ready SHALL be 1 in RUN and 0 in CLEAR; busy SHALL be the inverse.
REQ-020 In RUN, req=1 with wen=0 SHALL read word[addr]; rdata SHALL present that value after the same edge, and rvalid SHALL be 1 for exactly the following cycle (1-cycle latency).
REQ-021 rdata SHALL hold its last read value until the next accepted read; writes and clear sweeps SHALL NOT change rdata.
REQ-022 In RUN, req=1 with wen=1 SHALL update byte i of word[addr] to wdata[8i+7:8i] only where wmask[i]=1; other bytes SHALL be retained; rvalid SHALL stay 0.
REQ-023 A write with wmask all-zero SHALL be accepted with no array change.
REQ-024 Back-to-back accesses SHALL be accepted every cycle; a read of an address written on the immediately preceding edge SHALL return the newly written data.
REQ-025 req and clr_req SHALL be ignored while ready=0; no array change, no rvalid.
REQ-026 clr_req=1 in RUN SHALL move the FSM to CLEAR on that edge; ready SHALL drop for the next DEPTH cycles.
REQ-027 If req and clr_req are both 1 in RUN, the access SHALL complete on that edge (a read produces rvalid and rdata next cycle), and the sweep SHALL start on the following edge.
REQ-028 rvalid SHALL never be 1 during a cycle in which busy=1, except the rvalid of an access completed under REQ-027.
REQ-029 Out-of-range values are impossible since DEPTH is a power of two; the address SHALL be used unmodified.

Reset
REQ-030 While rst=1: ready=0, busy=1, rvalid=0, rdata=0, FSM=CLEAR, counter=0.
REQ-031 rst asserted mid-sweep or mid-access SHALL abort the operation immediately; the sweep SHALL restart at word 0 after deassert.
REQ-032 Array contents SHALL NOT be reset directly; they become defined only via the sweep.

Verification
REQ-033 W=32, DEPTH=16, CLR_VALUE=0xA5A5A5A5: deassert rst, count edges -> ready=1 after exactly 16 edges; reads of addr 0..15 -> 0xA5A5A5A5 each, rvalid one cycle after each req.
REQ-034 Write addr 3, wdata 0x11223344, wmask 0b0101, then read addr 3 -> rdata 0xA522A544; a following write to addr 4 leaves rdata at 0xA522A544.
REQ-035 Write addr 7 = 0xDEADBEEF (mask 0xF) on one edge, read addr 7 on the next edge -> rdata 0xDEADBEEF, rvalid=1 in the next cycle.
REQ-036 Read addr 7 together with clr_req=1 -> rvalid=1 with 0xDEADBEEF next cycle, ready=0 for 16 cycles, req during the sweep is ignored, then read addr 7 -> 0xA5A5A5A5.
REQ-037 Assert rst 5 edges into a sweep, release -> ready stays 0 for a full 16 further edges; all words read 0xA5A5A5A5.
REQ-038 W=8, DEPTH=2 corner: the sweep completes in 2 edges; single-byte mask writes and reads are correct at both addresses.
